// File: rtl/minv_reg_ctrl.sv
// Sequencer for the 256-bit modular-inverse V register: word-serial load,
// multi-bit right shift and non-destructive (rotating) word-serial readout.
module minv_reg_ctrl #(
  parameter int WORDS = 16,
  parameter int SHW   = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_start,
  input  logic           shift_start,
  input  logic [SHW-1:0] shift_amt,
  input  logic           read_start,
  input  logic [15:0]    din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [15:0]    dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  input  logic [15:0]    reg_lsw,
  output logic [15:0]    reg_din,
  output logic           reg_we,
  output logic           reg_sel_cyc,
  output logic           reg_sel_rs,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, READ} state_t;

  localparam logic [SHW-1:0] LAST = SHW'(WORDS - 1);
  localparam logic [SHW-1:0] ONE  = SHW'(1);

  state_t         state, state_nxt;
  logic [SHW-1:0] cnt, cnt_nxt;
  logic           done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // Commands only land in IDLE; load beats shift beats read.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end else if (shift_start) begin
          cnt_nxt = shift_amt;
          if (shift_amt == '0) done_nxt  = 1'b1;
          else                 state_nxt = SHIFT;
        end else if (read_start) begin
          state_nxt = READ;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (din_valid) begin
          cnt_nxt = cnt + ONE;
          if (cnt == LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      // cnt==1 marks the final shift write, so exactly shift_amt writes occur
      SHIFT: begin
        cnt_nxt = cnt - ONE;
        if (cnt == ONE) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      READ: begin
        if (dout_ready) begin
          cnt_nxt = cnt + ONE;
          if (cnt == LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    reg_we      = 1'b0;
    reg_sel_cyc = 1'b0;
    reg_sel_rs  = 1'b0;
    unique case (state)
      LOAD: begin
        din_ready = 1'b1;
        reg_we    = din_valid;
      end
      SHIFT: begin
        reg_we     = 1'b1;
        reg_sel_rs = 1'b1;
      end
      READ: begin
        dout_valid  = 1'b1;
        reg_we      = dout_ready;
        reg_sel_cyc = dout_ready;
      end
      default: ;
    endcase
  end

  assign dout    = reg_lsw;
  assign reg_din = din;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_minv_reg_ctrl.sv
// Scoreboard bench for minv_reg_ctrl with a behavioural model of the V register.
module tb_minv_reg_ctrl;
  localparam int WORDS = 16;
  localparam int SHW   = 9;
  localparam int W     = 16 * WORDS;

  logic           clk, rst_n;
  logic           load_start, shift_start, read_start;
  logic [SHW-1:0] shift_amt;
  logic [15:0]    din, dout, reg_lsw, reg_din;
  logic           din_valid, din_ready, dout_valid, dout_ready;
  logic           reg_we, reg_sel_cyc, reg_sel_rs, busy, done;

  minv_reg_ctrl #(.WORDS(WORDS), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .shift_start(shift_start),
    .shift_amt(shift_amt), .read_start(read_start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .reg_lsw(reg_lsw), .reg_din(reg_din), .reg_we(reg_we), .reg_sel_cyc(reg_sel_cyc),
    .reg_sel_rs(reg_sel_rs), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // V register: inserts at the top and moves right by a word, or shifts right one bit
  logic [W-1:0] vreg;
  always @(posedge clk)
    if (reg_we)
      vreg <= reg_sel_rs  ? {1'b0, vreg[W-1:1]} :
              reg_sel_cyc ? {reg_lsw, vreg[W-1:16]} : {reg_din, vreg[W-1:16]};
  assign reg_lsw = vreg[15:0];

  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, rs_cnt = 0, cyc_cnt = 0, ld_cnt = 0, done_cnt = 0;
  logic [15:0]  exp_q[$];
  logic [W-1:0] cur_exp;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_we) we_cnt <= we_cnt + 1;
    if (reg_we && reg_sel_rs) rs_cnt <= rs_cnt + 1;
    if (reg_we && reg_sel_cyc) cyc_cnt <= cyc_cnt + 1;
    if (reg_we && !reg_sel_rs && !reg_sel_cyc) ld_cnt <= ld_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (reg_we) chk("sel_excl", W'(reg_sel_rs & reg_sel_cyc), '0);
    if (reg_we && !reg_sel_rs && !(din_valid && din_ready) && !(dout_valid && dout_ready))
      chk("spurious_we", W'(reg_we), '0);
    if (done) chk("done_busy", W'(busy), '0);
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("read_extra", 1, 0);
      else chk("dout", W'(dout), W'(exp_q.pop_front()));
    end
  end

  function automatic logic [15:0] word(input int mode, input int k);
    return (mode == 0) ? 16'(k + 1) : 16'hFFFF;
  endfunction

  task automatic do_load(input int mode, input bit gappy, input bit with_shift, input bit mid_shift);
    int k = 0, i = 0;
    int ld0 = ld_cnt, rs0 = rs_cnt, d0 = done_cnt;
    bit acc;
    load_start = 1'b1; shift_start = with_shift; shift_amt = 9'd7;
    @(posedge clk); #1;
    load_start = 1'b0; shift_start = 1'b0;
    while (k < WORDS && i < 200) begin
      din = word(mode, k);
      din_valid = gappy ? (i % 2 == 0) : 1'b1;
      shift_start = mid_shift && (i == 3);
      @(negedge clk); acc = din_valid && din_ready;
      @(posedge clk); #1;
      if (acc) begin cur_exp[16*k +: 16] = word(mode, k); k++; end
      i++;
    end
    din_valid = 1'b0; shift_start = 1'b0;
    chk("load_words", W'(k), W'(WORDS));
    if (gappy) chk("load_gap_cycles", W'(i), W'(2*WORDS-1));
    chk("load_done", W'(done), 1);
    chk("load_busy", W'(busy), 0);
    @(posedge clk); #1;
    chk("load_done_pulse", W'(done), 0);
    chk("load_writes", W'(ld_cnt - ld0), W'(WORDS));
    chk("load_no_rs", W'(rs_cnt - rs0), 0);
    chk("load_done_cnt", W'(done_cnt - d0), 1);
    chk("load_reg", vreg, cur_exp);
  endtask

  task automatic do_shift(input int amt);
    int n = 1;
    int rs0 = rs_cnt, we0 = we_cnt;
    shift_amt = SHW'(amt); shift_start = 1'b1;
    @(posedge clk); #1;
    shift_start = 1'b0;
    while (!done && n < 600) begin @(posedge clk); #1; n++; end
    chk("shift_latency", W'(n), W'(amt + 1));
    chk("shift_busy", W'(busy), 0);
    @(posedge clk); #1;
    chk("shift_done_pulse", W'(done), 0);
    chk("shift_rs_writes", W'(rs_cnt - rs0), W'(amt));
    chk("shift_writes", W'(we_cnt - we0), W'(amt));
    cur_exp = cur_exp >> amt;
    chk("shift_reg", vreg, cur_exp);
  endtask

  task automatic do_read();
    int i = 0;
    int cyc0 = cyc_cnt, d0 = done_cnt;
    for (int k = 0; k < WORDS; k++) exp_q.push_back(cur_exp[16*k +: 16]);
    read_start = 1'b1;
    @(posedge clk); #1;
    read_start = 1'b0;
    while (!done && i < 300) begin
      dout_ready = (i % 3 != 2);
      @(posedge clk); #1;
      i++;
    end
    dout_ready = 1'b0;
    chk("read_done", W'(done), 1);
    @(posedge clk); #1;
    chk("read_done_pulse", W'(done), 0);
    chk("read_q_empty", W'(exp_q.size()), 0);
    chk("read_rot_writes", W'(cyc_cnt - cyc0), W'(WORDS));
    chk("read_done_cnt", W'(done_cnt - d0), 1);
    chk("read_reg_kept", vreg, cur_exp);
    exp_q.delete();
  endtask

  initial begin
    int rs0, d0;
    rst_n = 1'b0; load_start = 0; shift_start = 0; read_start = 0; shift_amt = '0;
    din = '0; din_valid = 0; dout_ready = 0; cur_exp = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_outs", W'({reg_we, din_ready, dout_valid, reg_sel_rs, reg_sel_cyc}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(0, 0, 0, 0);
    chk("load_pattern", vreg, 256'h0010_000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001);
    do_read();
    do_read();
    do_load(0, 1, 0, 0);
    do_load(1, 0, 0, 0);
    do_shift(5);
    chk("shift5_pattern", vreg, {5'b0, {(W-5){1'b1}}});
    do_shift(0);
    do_load(0, 0, 1, 0);
    do_load(0, 0, 0, 1);
    do_read();

    // reset in the middle of a long shift
    rs0 = rs_cnt;
    shift_amt = 9'd200; shift_start = 1'b1;
    @(posedge clk); #1;
    shift_start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", W'({reg_we, reg_sel_rs, busy, done, din_ready, dout_valid}), 0);
    d0 = done_cnt;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("abort_no_done", W'(done_cnt - d0), 0);
    chk("abort_writes", W'(rs_cnt - rs0), 49);
    chk("abort_idle", W'(busy), 0);

    do_load(0, 0, 0, 0);
    do_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
